// File: rtl/regfile_2r2w.sv
// Two-read/two-write register file with registered, write-first read ports and a
// built-in sequential clear. Define REGFILE_ZERO_REG_EN to hard-wire register 0 to zero.
module regfile_2r2w #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    output logic              ready,
    input  logic              wen_a,
    input  logic [ADDR_W-1:0] waddr_a,
    input  logic [DATA_W-1:0] din_a,
    input  logic              wen_b,
    input  logic [ADDR_W-1:0] waddr_b,
    input  logic [DATA_W-1:0] din_b,
    input  logic              ren_a,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [DATA_W-1:0] dout_a,
    input  logic              ren_b,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] dout_b,
    output logic              wr_conflict
);

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_e;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              ready_q, ready_d;
    logic [DATA_W-1:0] dout_a_q, dout_a_d;
    logic [DATA_W-1:0] dout_b_q, dout_b_d;
    logic              wr_conflict_q, wr_conflict_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic run_go;
    logic wa_ok, wb_ok;

    function automatic logic addr_ok(input logic [ADDR_W-1:0] addr);
`ifdef REGFILE_ZERO_REG_EN
        return (addr <= LAST) && (addr != '0);
`else
        return addr <= LAST;
`endif
    endfunction

    // Write-first read: port A's write wins over port B's, then the stored word.
    function automatic logic [DATA_W-1:0] read_word(input logic [ADDR_W-1:0] raddr);
        if (!addr_ok(raddr))
            return '0;
        else if (wa_ok && (waddr_a == raddr))
            return din_a;
        else if (wb_ok && (waddr_b == raddr))
            return din_b;
        else
            return mem_q[raddr];
    endfunction

    assign run_go = (state_q == S_RUN) && !clr;
    assign wa_ok  = run_go && wen_a && addr_ok(waddr_a);
    assign wb_ok  = run_go && wen_b && addr_ok(waddr_b);

    // NOTE: clocked state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_CLEAR;
            ptr_q         <= '0;
            ready_q       <= 1'b0;
            dout_a_q      <= '0;
            dout_b_q      <= '0;
            wr_conflict_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            ready_q       <= ready_d;
            dout_a_q      <= dout_a_d;
            dout_b_q      <= dout_b_d;
            wr_conflict_q <= wr_conflict_d;
        end
    end

    // NOTE: the array has no reset; the clear sequencer zeroes it one entry per cycle,
    // which keeps it mappable onto RAM.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == S_CLEAR) begin
                mem_q[ptr_q] <= '0;
            end else begin
                if (wb_ok) mem_q[waddr_b] <= din_b;
                if (wa_ok) mem_q[waddr_a] <= din_a;
            end
        end
    end

    // NOTE: defaults first in every always_comb so no path leaves a variable unassigned (no latches).
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            S_CLEAR: begin
                if (clr) begin
                    ptr_d = '0;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                    if (ptr_q == LAST) state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (clr) begin
                    state_d = S_CLEAR;
                    ptr_d   = '0;
                end
            end
            default: begin
                state_d = S_CLEAR;
                ptr_d   = '0;
            end
        endcase
    end

    always_comb begin
        ready_d       = (state_d == S_RUN);
        dout_a_d      = dout_a_q;
        dout_b_d      = dout_b_q;
        wr_conflict_d = wa_ok && wb_ok && (waddr_a == waddr_b);
        if (run_go && ren_a) dout_a_d = read_word(raddr_a);
        if (run_go && ren_b) dout_b_d = read_word(raddr_b);
    end

    assign ready       = ready_q;
    assign dout_a      = dout_a_q;
    assign dout_b      = dout_b_q;
    assign wr_conflict = wr_conflict_q;

endmodule

// File: tb/tb_regfile_2r2w.sv
// Self-checking bench for regfile_2r2w: a full-depth and a partial-depth instance share
// stimulus and are compared every cycle against an array-based reference model.
module tb_regfile_2r2w;

    localparam int DW = 32;
    localparam int AW = 5;
`ifdef REGFILE_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, clr;
    logic          wen_a, wen_b, ren_a, ren_b;
    logic [AW-1:0] waddr_a, waddr_b, raddr_a, raddr_b;
    logic [DW-1:0] din_a, din_b;

    logic          ready_o       [2];
    logic [DW-1:0] dout_a_o      [2];
    logic [DW-1:0] dout_b_o      [2];
    logic          wr_conflict_o [2];

    always #5 clk = ~clk;

    regfile_2r2w #(.DATA_W(DW), .DEPTH(32), .ADDR_W(AW)) dut_full (
        .clk(clk), .rst(rst), .clr(clr), .ready(ready_o[0]),
        .wen_a(wen_a), .waddr_a(waddr_a), .din_a(din_a),
        .wen_b(wen_b), .waddr_b(waddr_b), .din_b(din_b),
        .ren_a(ren_a), .raddr_a(raddr_a), .dout_a(dout_a_o[0]),
        .ren_b(ren_b), .raddr_b(raddr_b), .dout_b(dout_b_o[0]),
        .wr_conflict(wr_conflict_o[0])
    );

    regfile_2r2w #(.DATA_W(DW), .DEPTH(20), .ADDR_W(AW)) dut_part (
        .clk(clk), .rst(rst), .clr(clr), .ready(ready_o[1]),
        .wen_a(wen_a), .waddr_a(waddr_a), .din_a(din_a),
        .wen_b(wen_b), .waddr_b(waddr_b), .din_b(din_b),
        .ren_a(ren_a), .raddr_a(raddr_a), .dout_a(dout_a_o[1]),
        .ren_b(ren_b), .raddr_b(raddr_b), .dout_b(dout_b_o[1]),
        .wr_conflict(wr_conflict_o[1])
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference model: plain arrays; a write-first read equals a read after the writes land.
    int            depth_m [2] = '{32, 20};
    logic [DW-1:0] mem_m   [2][32];
    bit            clearing_m [2];
    int            next_clr_m [2];
    bit            rdy_m [2];
    logic [DW-1:0] da_m [2];
    logic [DW-1:0] db_m [2];
    bit            cf_m [2];
    bit            checking = 1'b0;

    function automatic bit addr_valid(input int d, input int addr);
        return (addr < d) && !(ZERO_REG && addr == 0);
    endfunction

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            int d = depth_m[i];
            bit va, vb;
            cf_m[i] = 1'b0;
            if (rst) begin
                clearing_m[i] = 1'b1;
                next_clr_m[i] = 0;
                rdy_m[i]      = 1'b0;
                da_m[i]       = '0;
                db_m[i]       = '0;
            end else if (clearing_m[i]) begin
                mem_m[i][next_clr_m[i]] = '0;
                if (clr) begin
                    next_clr_m[i] = 0;
                end else if (next_clr_m[i] == d - 1) begin
                    clearing_m[i] = 1'b0;
                    rdy_m[i]      = 1'b1;
                end else begin
                    next_clr_m[i]++;
                end
            end else if (clr) begin
                clearing_m[i] = 1'b1;
                next_clr_m[i] = 0;
                rdy_m[i]      = 1'b0;
            end else begin
                va = wen_a && addr_valid(d, int'(waddr_a));
                vb = wen_b && addr_valid(d, int'(waddr_b));
                if (vb) mem_m[i][waddr_b] = din_b;
                if (va) mem_m[i][waddr_a] = din_a;
                cf_m[i] = va && vb && (waddr_a == waddr_b);
                if (ren_a) da_m[i] = addr_valid(d, int'(raddr_a)) ? mem_m[i][raddr_a] : '0;
                if (ren_b) db_m[i] = addr_valid(d, int'(raddr_b)) ? mem_m[i][raddr_b] : '0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        if (checking) begin
            for (int i = 0; i < 2; i++) begin
                check($sformatf("d%0d_ready", depth_m[i]), DW'(ready_o[i]), DW'(rdy_m[i]));
                check($sformatf("d%0d_dout_a", depth_m[i]), dout_a_o[i], da_m[i]);
                check($sformatf("d%0d_dout_b", depth_m[i]), dout_b_o[i], db_m[i]);
                check($sformatf("d%0d_conflict", depth_m[i]), DW'(wr_conflict_o[i]), DW'(cf_m[i]));
            end
        end
    endtask

    task automatic idle();
        rst = 1'b0; clr = 1'b0;
        wen_a = 1'b0; waddr_a = '0; din_a = '0;
        wen_b = 1'b0; waddr_b = '0; din_b = '0;
        ren_a = 1'b0; raddr_a = '0;
        ren_b = 1'b0; raddr_b = '0;
    endtask

    // Counts edges until the full-depth instance raises ready; 0 means it never did.
    task automatic wait_ready(output int edges);
        edges = 0;
        for (int n = 1; n <= 64; n++) begin
            tick();
            if (ready_o[0] === 1'b1) begin
                edges = n;
                break;
            end
        end
    endtask

    initial begin
        int edges;
        idle();
        @(negedge clk);

        // Reset, then clear with a write held on port A that must be ignored.
        checking = 1'b1;
        rst = 1'b1;
        tick();
        check("rst_ready", DW'(ready_o[0]), '0);
        check("rst_dout_a", dout_a_o[0], '0);
        check("rst_dout_b", dout_b_o[0], '0);
        check("rst_conflict", DW'(wr_conflict_o[0]), '0);
        rst = 1'b0;
        wen_a = 1'b1; waddr_a = 5'd3; din_a = 32'h0000_DEAD;
        wait_ready(edges);
        check("clear_len", DW'(edges), 32);
        idle();
        ren_a = 1'b1; raddr_a = 5'd3;
        tick();
        check("clear_reg3", dout_a_o[0], '0);

        // Write via B forwarded to a same-edge read on A, then a plain read on B.
        idle();
        wen_b = 1'b1; waddr_b = 5'd7; din_b = 32'h1234_5678;
        ren_a = 1'b1; raddr_a = 5'd7;
        tick();
        check("fwd_b_to_a", dout_a_o[0], 32'h1234_5678);
        idle();
        ren_b = 1'b1; raddr_b = 5'd7;
        tick();
        check("read_b_7", dout_b_o[0], 32'h1234_5678);

        // Write conflict on register 9.
        idle();
        wen_a = 1'b1; waddr_a = 5'd9; din_a = 32'hAAAA_0000;
        wen_b = 1'b1; waddr_b = 5'd9; din_b = 32'h0000_BBBB;
        tick();
        check("conflict_hi", DW'(wr_conflict_o[0]), 1);
        idle();
        ren_a = 1'b1; raddr_a = 5'd9;
        tick();
        check("conflict_lo", DW'(wr_conflict_o[0]), 0);
        check("conflict_data", dout_a_o[0], 32'hAAAA_0000);

        // Hold with read disabled, and out-of-range access on the 20-deep instance.
        idle();
        wen_a = 1'b1; waddr_a = 5'd4; din_a = 32'h55;
        tick();
        idle();
        ren_a = 1'b1; raddr_a = 5'd4;
        tick();
        idle();
        repeat (3) tick();
        check("hold_a", dout_a_o[0], 32'h55);
        wen_a = 1'b1; waddr_a = 5'd25; din_a = 32'h0000_CAFE;
        ren_a = 1'b1; raddr_a = 5'd25;
        tick();
        check("range_rd_a", dout_a_o[1], '0);
        idle();
        ren_b = 1'b1; raddr_b = 5'd25;
        tick();
        check("range_rd_b", dout_b_o[1], '0);

        // Fill with index, clear mid-operation, then a restarted clear.
        idle();
        for (int i = 0; i < 16; i++) begin
            wen_a = 1'b1; waddr_a = AW'(2 * i);     din_a = DW'(2 * i);
            wen_b = 1'b1; waddr_b = AW'(2 * i + 1); din_b = DW'(2 * i + 1);
            tick();
        end
        idle();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_ready_lo", DW'(ready_o[0]), 0);
        wait_ready(edges);
        check("clr_len", DW'(edges), 32);
        for (int i = 0; i < 32; i++) begin
            ren_a = 1'b1; raddr_a = AW'(i);
            ren_b = 1'b1; raddr_b = AW'(31 - i);
            tick();
        end
        check("clr_reg31", dout_a_o[0], '0);
        idle();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        repeat (9) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        wait_ready(edges);
        check("reclr_len", DW'(edges), 32);

        // Register 0 write with same-edge read.
        idle();
        wen_a = 1'b1; waddr_a = '0; din_a = 32'hFFFF_FFFF;
        ren_a = 1'b1; raddr_a = '0;
        tick();
        check("zero_reg_dout", dout_a_o[0], ZERO_REG ? 32'h0 : 32'hFFFF_FFFF);
        check("zero_reg_conflict", DW'(wr_conflict_o[0]), 0);

        // Randomized traffic with collisions favoured, occasional clears and resets.
        for (int n = 0; n < 3000; n++) begin
            rst     = ($urandom_range(0, 499) == 0);
            clr     = ($urandom_range(0, 63) == 0);
            wen_a   = $urandom_range(0, 1) == 1;
            wen_b   = $urandom_range(0, 1) == 1;
            ren_a   = $urandom_range(0, 3) != 0;
            ren_b   = $urandom_range(0, 3) != 0;
            waddr_a = AW'($urandom_range(0, 1) == 1 ? $urandom_range(0, 3) : $urandom_range(0, 31));
            waddr_b = AW'($urandom_range(0, 1) == 1 ? $urandom_range(0, 3) : $urandom_range(0, 31));
            raddr_a = AW'($urandom_range(0, 1) == 1 ? $urandom_range(0, 3) : $urandom_range(0, 31));
            raddr_b = AW'($urandom_range(0, 1) == 1 ? $urandom_range(0, 3) : $urandom_range(0, 31));
            din_a   = $urandom;
            din_b   = $urandom;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_2r2w.md
# regfile_2r2w

Parametrised two-read/two-write register file, the next-generation CPU register store. Depth, data width and address width are parameters. Read ports are registered, and a write to the register being read in the same cycle is forwarded to the reader. Writes to the same register from both ports resolve deterministically. After reset or on request, a built-in sequencer clears the array one entry per cycle, and `ready` reports when the file is usable.

## Interface
- `DATA_W`, 32, word width in bits
- `DEPTH`, 32, number of registers; must satisfy 2 ≤ `DEPTH` ≤ 2^`ADDR_W`
- `ADDR_W`, 5, register address width

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `clr`  in  1  request to clear the whole array (sampled on the clock edge)
- `ready`  out  1  high when the file accepts reads and writes
- `wen_a`  in  1  write enable, port A
- `waddr_a`  in  `ADDR_W`  write address, port A
- `din_a`  in  `DATA_W`  write data, port A
- `wen_b`  in  1  write enable, port B
- `waddr_b`  in  `ADDR_W`  write address, port B
- `din_b`  in  `DATA_W`  write data, port B
- `ren_a`  in  1  read enable, port A
- `raddr_a`  in  `ADDR_W`  read address, port A
- `dout_a`  out  `DATA_W`  registered read data, port A
- `ren_b`  in  1  read enable, port B
- `raddr_b`  in  `ADDR_W`  read address, port B
- `dout_b`  out  `DATA_W`  registered read data, port B
- `wr_conflict`  out  1  one-cycle flag: both ports wrote the same register

## Operation
- The block has two states, CLEAR and RUN, and a clear pointer `ptr` of `ADDR_W` bits.
- Reset (`rst`=1 at an edge): state←CLEAR, `ptr`←0, `ready`←0, `dout_a`/`dout_b`←0, `wr_conflict`←0. The memory array itself is not reset; the sequencer clears it.
- CLEAR state, each edge:
  - mem[`ptr`]←0 and `ptr`←`ptr`+1.
  - When `ptr`=`DEPTH`-1: state←RUN and `ready`←1.
  - All write and read enables are ignored; `dout_*` holds its value.
- RUN state, `clr`=1: state←CLEAR, `ptr`←0, `ready`←0. Writes and reads at that edge are ignored.
- `clr`=1 while in CLEAR: `ptr` restarts at 0.
- `rst` has priority over `clr`, and `clr` has priority over port traffic.
- Write, RUN state:
  - A port with its enable high and address < `DEPTH` writes its data.
  - An address ≥ `DEPTH` is dropped silently.
- Write conflict (both ports valid, same address): port A's data is stored, and `wr_conflict`←1 for one cycle. `wr_conflict` is 0 on every other edge.
- Read, RUN state:
  - `ren_x`=1: `dout_x` is loaded with the contents of `raddr_x`.
  - An address ≥ `DEPTH` loads 0.
  - `ren_x`=0: `dout_x` holds its previous value.
- Bypass (write-first): if an enabled, valid write at the same edge targets `raddr_x`, `dout_x` is loaded with that write's data. If both writes target it, port A's data is used.
- Both read ports may read the same address in the same cycle.

## Timing
- Read latency is 1 cycle: data for the address presented at edge N appears on `dout_x` after edge N.
- Write-to-read latency is 0 cycles because of bypass. A plain read of the written register at edge N+1 returns the new value.
- Clear duration is `DEPTH` edges. Starting with the first edge in CLEAR, edge k clears register k-1. `ready` goes high on edge `DEPTH`.
- Cycle count for default parameters: `rst` high at edge 0, then low → `ready`=1 after edge 32.
- `ready` is a registered output with no combinational path from any input.
- Reset values: `ready`=0, `dout_a`=0, `dout_b`=0, `wr_conflict`=0.

## Configuration
- `REGFILE_ZERO_REG_EN` defined:
  - Register 0 is hard-wired to zero.
  - Writes to address 0 are dropped and raise no conflict.
  - Reads of address 0 return 0, with no bypass.
- `REGFILE_ZERO_REG_EN` undefined: register 0 behaves as an ordinary register.

## Test plan
- Clear after reset: assert `rst` for 1 edge, then hold `wen_a`=1, `waddr_a`=3, `din_a`=0xDEAD during clear → `ready` rises after exactly 32 edges; afterwards reading register 3 returns 0.
- Basic write/read and forwarding: write 0x12345678 to register 7 via port B while port A reads 7 at the same edge → `dout_a`=0x12345678 after that edge; port B reading 7 at the next edge also returns 0x12345678.
- Write conflict: port A writes 0xAAAA0000 and port B writes 0x0000BBBB to register 9 at the same edge → `wr_conflict`=1 for one cycle; register 9 then reads 0xAAAA0000.
- Hold and range: write 0x55 to register 4, read it, then drop `ren_a` for 3 cycles → `dout_a` stays 0x55. With `DEPTH`=20 and `ADDR_W`=5, a write to address 25 is dropped and a read of address 25 returns 0.
- Mid-operation clear: fill registers 0–31 with their index, pulse `clr` → `ready`=0 next cycle, then high again after 32 edges; all registers read 0. A second `clr` pulse at edge 10 of the clear restarts the count, so `ready` rises 32 edges after that pulse.
- Zero register, with `REGFILE_ZERO_REG_EN` defined: write 0xFFFFFFFF to register 0 while reading 0 → `dout_a`=0 and `wr_conflict`=0. Without the macro, the same stimulus gives `dout_a`=0xFFFFFFFF.
